// File: rtl/cordic_multimode_iter.sv
// Iterative CORDIC engine, rotation and vectoring modes.
// One shared micro-rotation stage is reused over ITERS cycles.
module cordic_multimode_iter #(
    parameter int BITS  = 16,
    parameter int GUARD = 3,
    parameter int ITERS = 14
) (
    input  logic                   i_clk,
    input  logic                   i_rst_n,
    input  logic                   i_en,
    input  logic                   i_valid,
    output logic                   o_ready,
    input  logic                   i_mode,
    input  logic signed [BITS-1:0] i_x,
    input  logic signed [BITS-1:0] i_y,
    input  logic signed [BITS-1:0] i_z,
    output logic                   o_valid,
    input  logic                   i_ready,
    output logic signed [BITS-1:0] o_x,
    output logic signed [BITS-1:0] o_y,
    output logic signed [BITS-1:0] o_z,
    output logic                   o_busy
);

    localparam int XW = BITS + GUARD + 1;
    localparam int ZW = BITS + GUARD;
    localparam int CW = (ITERS > 1) ? $clog2(ITERS) : 1;
    localparam logic signed [ZW-1:0] QPI = ZW'(2 ** (ZW - 2));
    localparam logic signed [BITS-1:0] OMAX = {1'b0, {(BITS-1){1'b1}}};
    localparam logic signed [BITS-1:0] OMIN = {1'b1, {(BITS-1){1'b0}}};

    // atan(2^-i) with 2^31 == pi
    localparam logic [31:0] ATAN [16] = '{
        32'h20000000, 32'h12E4051D, 32'h09FB385B, 32'h051111D4,
        32'h028B0D43, 32'h0145D7E1, 32'h00A2F61E, 32'h00517C55,
        32'h0028BE53, 32'h00145F2E, 32'h000A2F98, 32'h000517CC,
        32'h00028BE6, 32'h000145F3, 32'h0000A2F9, 32'h0000517C
    };

    typedef enum logic [1:0] {IDLE, PRE, ITER, DONE} state_t;

    state_t                 state_q;
    logic signed [XW-1:0]   x_q, y_q;
    logic signed [ZW-1:0]   z_q;
    logic                   mode_q;
    logic [CW-1:0]          cnt_q;
    logic                   valid_q;
    logic signed [BITS-1:0] ox_q, oy_q, oz_q;

    logic signed [XW-1:0]   xsh, ysh, x_d, y_d;
    logic signed [ZW-1:0]   z_d, atan_c;
    logic                   d_pos, fold;

    function automatic logic signed [ZW-1:0] atan_rnd(input logic [CW-1:0] idx);
        logic [3:0]  k;
        logic [32:0] t;
        k = 4'(idx);
        t = {1'b0, ATAN[k]} + (33'd1 << (31 - ZW));
        return t[32-ZW +: ZW];
    endfunction

    function automatic logic signed [BITS-1:0] out_xy(input logic signed [XW-1:0] v);
        logic signed [XW:0] t;
        t = {v[XW-1], v} + (XW+1)'(2 ** (GUARD - 1));
        t = t >>> GUARD;
        if ((&t[XW:BITS-1]) || !(|t[XW:BITS-1]))
            return t[BITS-1:0];
        return t[XW] ? OMIN : OMAX;
    endfunction

    function automatic logic signed [BITS-1:0] out_z(input logic signed [ZW-1:0] v);
        logic [ZW-1:0] t;
        t = v + ZW'(2 ** (GUARD - 1));
        return t[ZW-1:GUARD];
    endfunction

    always_comb begin
        xsh    = x_q >>> cnt_q;
        ysh    = y_q >>> cnt_q;
        atan_c = atan_rnd(cnt_q);
        d_pos  = mode_q ? y_q[XW-1] : ~z_q[ZW-1];
        if (d_pos) begin
            x_d = x_q - ysh;
            y_d = y_q + xsh;
            z_d = z_q - atan_c;
        end else begin
            x_d = x_q + ysh;
            y_d = y_q - xsh;
            z_d = z_q + atan_c;
        end
        if (mode_q)
            fold = x_q[XW-1];
        else
            fold = (z_q > QPI) || (z_q < -QPI);
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q <= IDLE;
            x_q     <= '0;
            y_q     <= '0;
            z_q     <= '0;
            mode_q  <= 1'b0;
            cnt_q   <= '0;
            valid_q <= 1'b0;
            ox_q    <= '0;
            oy_q    <= '0;
            oz_q    <= '0;
        end else if (i_en) begin
            unique case (state_q)
                IDLE: begin
                    if (i_valid) begin
                        x_q     <= {i_x[BITS-1], i_x, {GUARD{1'b0}}};
                        y_q     <= {i_y[BITS-1], i_y, {GUARD{1'b0}}};
                        z_q     <= {i_z, {GUARD{1'b0}}};
                        mode_q  <= i_mode;
                        state_q <= PRE;
                    end
                end
                PRE: begin
                    // +/- pi is a flip of the angle MSB under wrap
                    if (fold) begin
                        x_q <= -x_q;
                        y_q <= -y_q;
                        z_q <= {~z_q[ZW-1], z_q[ZW-2:0]};
                    end
                    cnt_q   <= '0;
                    state_q <= ITER;
                end
                ITER: begin
                    x_q <= x_d;
                    y_q <= y_d;
                    z_q <= z_d;
                    if (cnt_q == CW'(ITERS - 1)) begin
                        ox_q    <= out_xy(x_d);
                        oy_q    <= out_xy(y_d);
                        oz_q    <= out_z(z_d);
                        valid_q <= 1'b1;
                        state_q <= DONE;
                    end else begin
                        cnt_q <= cnt_q + CW'(1);
                    end
                end
                DONE: begin
                    if (i_ready) begin
                        valid_q <= 1'b0;
                        state_q <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign o_ready = (state_q == IDLE);
    assign o_busy  = (state_q == PRE) || (state_q == ITER);
    assign o_valid = valid_q;
    assign o_x     = ox_q;
    assign o_y     = oy_q;
    assign o_z     = oz_q;

endmodule

// File: tb/tb_cordic_multimode_iter.sv
// Directed bench for cordic_multimode_iter.
// Expected values are hand-computed constants with tolerances.
module tb_cordic_multimode_iter;

    logic               clk;
    logic               rst_n;
    logic               en;
    logic               valid_in;
    logic               ready_out;
    logic               mode;
    logic signed [15:0] x_in, y_in, z_in;
    logic               valid_out;
    logic               ready_in;
    logic signed [15:0] x_out, y_out, z_out;
    logic               busy;

    int errors = 0;
    int checks = 0;
    int lat;
    int seen;

    cordic_multimode_iter #(.BITS(16), .GUARD(3), .ITERS(14)) dut (
        .i_clk   (clk),
        .i_rst_n (rst_n),
        .i_en    (en),
        .i_valid (valid_in),
        .o_ready (ready_out),
        .i_mode  (mode),
        .i_x     (x_in),
        .i_y     (y_in),
        .i_z     (z_in),
        .o_valid (valid_out),
        .i_ready (ready_in),
        .o_x     (x_out),
        .o_y     (y_out),
        .o_z     (z_out),
        .o_busy  (busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input int act, input int exp,
                       input int tol, input bit wrap);
        int d;
        logic ok;
        checks++;
        d = act - exp;
        if (wrap) d = int'($signed(16'(d)));
        ok = (d <= tol) && (d >= -tol);
        assert (ok === 1'b1) else begin
            errors++;
            $error("FAIL %s: got %0d expected %0d (tol %0d)", tag, act, exp, tol);
        end
    endtask

    task automatic run_op(input logic m, input int x, input int y, input int z,
                          input bit stall, output int l);
        int g;
        g = 0;
        while (!ready_out && g < 50) begin
            @(posedge clk); #1; g++;
        end
        mode     = m;
        x_in     = 16'(x);
        y_in     = 16'(y);
        z_in     = 16'(z);
        valid_in = 1'b1;
        @(posedge clk); #1;
        valid_in = 1'b0;
        l = 1;
        while (!valid_out && l < 60) begin
            if (stall) en = (l >= 5 && l < 8) ? 1'b0 : 1'b1;
            @(posedge clk); #1;
            l++;
        end
        en = 1'b1;
    endtask

    task automatic accept_result();
        ready_in = 1'b1;
        @(posedge clk); #1;
        ready_in = 1'b0;
    endtask

    initial begin
        clk = 0; rst_n = 0; en = 1; valid_in = 0; ready_in = 0;
        mode = 0; x_in = 0; y_in = 0; z_in = 0;

        repeat (2) @(posedge clk);
        #1;
        chk("rst_valid", valid_out, 0, 0, 0);
        chk("rst_busy", busy, 0, 0, 0);
        chk("rst_x", x_out, 0, 0, 0);
        chk("rst_y", y_out, 0, 0, 0);
        chk("rst_z", z_out, 0, 0, 0);
        rst_n = 1;
        @(posedge clk); #1;
        chk("rst_ready", ready_out, 1, 0, 0);

        run_op(1'b0, 9949, 0, 5461, 1'b0, lat);
        chk("rot30_lat", lat, 16, 0, 0);
        chk("rot30_x", x_out, 14189, 4, 0);
        chk("rot30_y", y_out, 8192, 4, 0);
        chk("rot30_z", z_out, 0, 8, 1);
        chk("done_ready", ready_out, 0, 0, 0);
        chk("done_busy", busy, 0, 0, 0);

        valid_in = 1'b1; mode = 1'b1; x_in = 16'sd1000; y_in = 16'sd2000;
        for (int k = 0; k < 5; k++) begin
            @(posedge clk); #1;
            chk("hold_valid", valid_out, 1, 0, 0);
            chk("hold_ready", ready_out, 0, 0, 0);
            chk("hold_x", x_out, 14189, 4, 0);
            chk("hold_y", y_out, 8192, 4, 0);
            chk("hold_z", z_out, 0, 8, 1);
        end
        valid_in = 1'b0;
        accept_result();
        chk("acc_valid", valid_out, 0, 0, 0);
        chk("acc_ready", ready_out, 1, 0, 0);
        @(posedge clk); #1;
        chk("acc_nostart", busy, 0, 0, 0);

        run_op(1'b0, 9949, 0, -27307, 1'b0, lat);
        chk("fold150_x", x_out, -14189, 4, 0);
        chk("fold150_y", y_out, -8192, 4, 0);
        accept_result();

        run_op(1'b0, 9949, 0, -32768, 1'b0, lat);
        chk("foldpi_x", x_out, -16384, 4, 0);
        chk("foldpi_y", y_out, 0, 4, 0);
        accept_result();

        run_op(1'b1, 8192, 8192, 0, 1'b0, lat);
        chk("vec45_lat", lat, 16, 0, 0);
        chk("vec45_z", z_out, 8192, 8, 1);
        chk("vec45_x", x_out, 19079, 6, 0);
        chk("vec45_y", y_out, 0, 4, 0);
        accept_result();

        run_op(1'b1, -8192, 0, 0, 1'b0, lat);
        chk("vecneg_z", z_out, -32768, 8, 1);
        chk("vecneg_x", x_out, 13491, 6, 0);
        accept_result();

        run_op(1'b1, 16383, 16383, 0, 1'b0, lat);
        chk("sat_x", x_out, 32767, 0, 0);
        chk("sat_z", z_out, 8192, 8, 1);
        accept_result();

        run_op(1'b0, 9949, 0, 5461, 1'b1, lat);
        chk("stall_lat", lat, 19, 0, 0);
        chk("stall_x", x_out, 14189, 4, 0);
        chk("stall_y", y_out, 8192, 4, 0);
        chk("stall_z", z_out, 0, 8, 1);
        accept_result();

        mode = 1'b0; x_in = 16'sd9949; y_in = 16'sd0; z_in = 16'sd5461;
        valid_in = 1'b1;
        @(posedge clk); #1;
        valid_in = 1'b0;
        repeat (6) @(posedge clk);
        #1;
        chk("midrst_busy", busy, 1, 0, 0);
        rst_n = 1'b0;
        #1;
        chk("midrst_x", x_out, 0, 0, 0);
        chk("midrst_y", y_out, 0, 0, 0);
        chk("midrst_z", z_out, 0, 0, 0);
        chk("midrst_valid", valid_out, 0, 0, 0);
        chk("midrst_busyoff", busy, 0, 0, 0);
        #10;
        rst_n = 1'b1;
        @(posedge clk); #1;
        chk("postrst_ready", ready_out, 1, 0, 0);
        seen = 0;
        for (int k = 0; k < 20; k++) begin
            @(posedge clk); #1;
            if (valid_out) seen++;
        end
        chk("postrst_novalid", seen, 0, 0, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/cordic_multimode_iter.md
Name: cordic_multimode_iter

Overview:
- Iterative, area-reduced CORDIC engine: one shared micro-rotation datapath reused over ITERS cycles per operation.
- Supports two modes:
  - Rotation mode: sin/cos generation, vector rotation.
  - Vectoring mode: atan2 and magnitude.
- Generalises the existing pipelined sin/cos stages with:
  - a selectable mode,
  - full-circle quadrant pre-rotation,
  - internal guard bits,
  - output saturation,
  - a valid/ready handshake.
- Sits between the UART command decoder and the response formatter. One operation is in flight at a time.

Parameters:
- BITS, 16, width of x/y/z ports (signed).
- GUARD, 3, extra LSBs carried internally on x, y and z.
- ITERS, 14, micro-rotations per operation. Range 1..MAX_STAGES (pkg_cordic_sincos).

Ports:
- i_clk  in  1  clock.
- i_rst_n  in  1  asynchronous active-low reset.
- i_en  in  1  global enable. When low, all state and outputs freeze.
- i_valid  in  1  input operation valid.
- o_ready  out  1  engine can accept; high only in IDLE.
- i_mode  in  1  0 = rotation (drive z to 0), 1 = vectoring (drive y to 0).
- i_x  in  BITS  signed x, Q2.(BITS-2).
- i_y  in  BITS  signed y, Q2.(BITS-2).
- i_z  in  BITS  signed angle; full scale ±2^(BITS-1) = ±pi.
- o_valid  out  1  result valid; held until accepted.
- i_ready  in  1  downstream accepts result.
- o_x  out  BITS  result x (saturated).
- o_y  out  BITS  result y (saturated).
- o_z  out  BITS  result angle (wraps mod 2pi).
- o_busy  out  1  high in PRE or ITER.

Behaviour:
- Reset: state IDLE, iteration counter 0. o_valid=0, o_busy=0, o_x=o_y=o_z=0. o_ready=1 after reset release.
- Reset asserted mid-operation aborts it. No result is produced.
- All transitions below occur only on cycles with i_en=1.
- IDLE:
  - Accept when i_valid & o_ready.
  - Capture x, y into BITS+GUARD+1-bit registers, left-shifted by GUARD. The extra MSB absorbs CORDIC gain growth.
  - Capture z into BITS+GUARD, and capture mode. Go to PRE.
- PRE (1 cycle), quadrant fold:
  - Rotation mode, |z| > pi/2: negate x and y; z := z − pi, with two's-complement wrap on BITS+GUARD.
  - Rotation mode, z = −pi exactly: fold as well.
  - Vectoring mode, x < 0: negate x and y; z := z + pi (wrap).
  - Vectoring mode, x = 0: no fold.
  - Clear counter i. Go to ITER.
- ITER (ITERS cycles, i = 0..ITERS−1):
  - Direction d = +1 when (rotation: z ≥ 0) or (vectoring: y < 0); else d = −1.
  - x' = x − d·(y>>>i); y' = y + d·(x>>>i); z' = z − d·atan_i.
  - atan_i = pkg_cordic_sincos ATAN[i], rounded to BITS+GUARD in the same angle scale.
  - After i = ITERS−1, go to DONE.
- DONE:
  - Outputs are registered on DONE entry.
  - o_x/o_y: internal value rounded (round-half-up) and shifted right by GUARD, then saturated to [−2^(BITS−1), 2^(BITS−1)−1].
  - o_z: rounded and shifted right by GUARD, wrapping.
  - o_valid=1 until o_valid & i_ready, then go to IDLE.
  - o_ready is low in DONE. No same-cycle accept of a new operation: there is 1 bubble cycle.
- Latency: accept at cycle N, o_valid at cycle N+ITERS+2 (with i_en held high).
- Gain: no compensation is applied; results scale by K ≈ 1.6468. Callers pre-scale by 1/K when unity gain is required.
- i_valid held while o_ready=0 is ignored. Inputs are sampled only at accept.
- o_x, o_y and o_z are stable throughout DONE, and also while i_en=0.

Test Plan:
- Rotation, BITS=16, GUARD=3, ITERS=14: x=9949 (1/K), y=0, z=5461 (pi/6) → o_x=14189±4, o_y=8192±4, o_z within ±8 of 0. o_valid rises exactly 16 cycles after accept.
- Rotation fold: x=9949, y=0, z=−27307 (−5pi/6) → o_x=−14189±4, o_y=−8192±4. Also x=9949, y=0, z=−32768 (−pi) → o_x=−16384±4, o_y=0±4.
- Vectoring: x=8192, y=8192, z=0 → o_z=8192±8 (pi/4), o_x=19079±6, o_y=0±4. Also x=−8192, y=0 → o_z=−32768±8 (wrap), o_x=13491±6.
- Saturation: vectoring x=16383, y=16383 → o_x=32767 (clamped), o_z=8192±8.
- Handshake and stall:
  - Hold i_ready=0 for 5 cycles in DONE → o_valid and all outputs constant, o_ready=0, new i_valid ignored.
  - i_en=0 for 3 cycles mid-ITER → latency grows by exactly 3 and the result is unchanged.
- Reset mid-ITER: assert i_rst_n=0 at iteration 5 → all outputs 0 immediately. After release, o_ready=1 and no spurious o_valid.
